// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: word width, the canonical NOP encoding,
// and the instruction-memory fetch FSM states.
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] MIPS_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_fetch_if.sv
// Load-port and fetch-port bundle of the instruction-memory fetch stage.
// The slave side is the fetch block; the master side is the loader/PC driver.
interface imem_fetch_if #(
  parameter int ADDR_W = 8
);
  import mips_pkg::*;

  logic              load_valid;
  logic              load_ready;
  logic [WORD_W-1:0] load_data;
  logic              load_last;

  logic [WORD_W-1:0] pc;
  logic              fetch_en;
  logic [WORD_W-1:0] instr;
  logic              instr_valid;

  logic [ADDR_W:0]   prog_size;
  logic              loading;
  logic              misalign;
  logic              eof;

  modport slave (
    input  load_valid, load_data, load_last, pc, fetch_en,
    output load_ready, instr, instr_valid, prog_size, loading, misalign, eof
  );

  modport master (
    output load_valid, load_data, load_last, pc, fetch_en,
    input  load_ready, instr, instr_valid, prog_size, loading, misalign, eof
  );

endinterface

// File: rtl/imem_ram.sv
// Simple dual-port synchronous RAM: one write port for image loading and one
// registered read port for fetches. The read register holds when re_i is low.
module imem_ram
  import mips_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/imem_fetch.sv
// Instruction-memory fetch stage: loads a program image, then serves
// registered reads at pc>>2 and flags end-of-program once pc leaves the image.
// Optional alignment checking is enabled with `define IMEM_ALIGN_CHECK_EN.
module imem_fetch
  import mips_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic         clock,
  input  logic         reset,
  imem_fetch_if.slave  bus
);

  localparam int unsigned LAST_PTR = DEPTH - 1;

  imem_state_e       state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              nop_sel_q, nop_sel_d;
  logic              misalign_q, misalign_d;
  logic              eof_q, eof_d;

  logic              load_hs;
  logic              ram_re;
  logic              mis_pc;
  logic              in_range;
  logic [29:0]       idx;
  logic [WORD_W-1:0] ram_rdata;

  // Full 30-bit word index so a huge pc never aliases into the memory.
  assign idx      = bus.pc[31:2];
  assign in_range = idx < {{(29 - ADDR_W){1'b0}}, wr_ptr_q};
  assign load_hs  = (state_q == LOAD) && bus.load_valid;

`ifdef IMEM_ALIGN_CHECK_EN
  assign mis_pc = bus.pc[1:0] != 2'b00;
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^bus.pc[1:0];
  assign mis_pc        = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= LOAD;
      wr_ptr_q      <= '0;
      instr_valid_q <= 1'b0;
      nop_sel_q     <= 1'b1;
      misalign_q    <= 1'b0;
      eof_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      instr_valid_q <= instr_valid_d;
      nop_sel_q     <= nop_sel_d;
      misalign_q    <= misalign_d;
      eof_q         <= eof_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    instr_valid_d = 1'b0;
    nop_sel_d     = nop_sel_q;
    misalign_d    = 1'b0;
    eof_d         = eof_q;
    ram_re        = 1'b0;
    case (state_q)
      LOAD: begin
        if (load_hs) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (bus.load_last || wr_ptr_q == LAST_PTR[ADDR_W:0]) state_d = RUN;
        end
      end
      RUN: begin
        if (bus.fetch_en) begin
          instr_valid_d = 1'b1;
          // Misalignment wins over the range check and leaves eof/state alone.
          if (mis_pc) begin
            nop_sel_d  = 1'b1;
            misalign_d = 1'b1;
          end else if (in_range) begin
            nop_sel_d = 1'b0;
            ram_re    = 1'b1;
          end else begin
            nop_sel_d = 1'b1;
            eof_d     = 1'b1;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        nop_sel_d     = 1'b1;
        instr_valid_d = bus.fetch_en;
      end
      default: state_d = LOAD;
    endcase
  end

  // Instruction register lives in the RAM read port; NOP is selected on top.
  imem_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (load_hs),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (bus.load_data),
    .re_i    (ram_re),
    .raddr_i (idx[ADDR_W-1:0]),
    .rdata_o (ram_rdata)
  );

  assign bus.load_ready  = state_q == LOAD;
  assign bus.loading     = state_q == LOAD;
  assign bus.instr       = nop_sel_q ? MIPS_NOP : ram_rdata;
  assign bus.instr_valid = instr_valid_q;
  assign bus.prog_size   = wr_ptr_q;
  assign bus.misalign    = misalign_q;
  assign bus.eof         = eof_q;

endmodule

// File: tb/tb_imem_fetch.sv
// Randomized self-checking bench for imem_fetch; expected responses come from
// a program-image queue model driven by the load/fetch rules.
module tb_imem_fetch;
  import mips_pkg::*;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
`ifdef IMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  imem_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  imem_fetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total  = 0;
  int passed = 0;

  logic [31:0] img[$];
  bit          m_loading;
  bit          m_eof;

  task automatic idle();
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    bus.pc         = '0;
    bus.fetch_en   = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    img.delete();
    m_loading = 1'b1;
    m_eof     = 1'b0;
  endtask

  task automatic load_words(input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = $urandom;
      bus.load_valid = 1'b1;
      bus.load_data  = w;
      bus.load_last  = last && (i == n - 1);
      @(posedge clock); #1;
      if (m_loading) begin
        img.push_back(w);
        if (bus.load_last || img.size() == DEPTH) m_loading = 1'b0;
      end
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic fetch_cycle(input logic [31:0] pc, input bit en);
    bus.pc       = pc;
    bus.fetch_en = en;
    @(posedge clock); #1;
    bus.fetch_en = 1'b0;
  endtask

  // Reference: what a fetch of byte address pc should return given the image.
  function automatic void model_fetch(input logic [31:0] pc, output logic [31:0] ei,
                                      output logic em);
    logic [31:0] idx;
    idx = {2'b00, pc[31:2]};
    ei  = MIPS_NOP;
    em  = 1'b0;
    if (m_eof) ei = MIPS_NOP;
    else if (ALIGN_CHK && pc[1:0] != 2'b00) em = 1'b1;
    else if (idx < img.size()) ei = img[idx];
    else m_eof = 1'b1;
  endfunction

  task automatic test_reset();
    logic [45:0] got, exp;
    idle();
    reset = 1'b1;
    #3;
    got = {bus.load_ready, bus.loading, bus.instr, bus.instr_valid, bus.prog_size,
           bus.misalign, bus.eof};
    exp = {1'b1, 1'b1, 32'h0, 1'b0, 9'd0, 1'b0, 1'b0};
    total++;
    if (got !== exp) $display("FAIL reset_state: got %h expected %h", got, exp);
    else passed++;
    @(posedge clock); #1;
    reset = 1'b0;
    img.delete();
    m_loading = 1'b1;
    m_eof     = 1'b0;
  endtask

  task automatic test_load_fetch();
    logic [31:0] ei, w;
    logic        em;
    do_reset();
    load_words(3, 1'b0);
    // last word and a fetch in the same cycle: the fetch must be dropped
    w = $urandom;
    bus.load_valid = 1'b1; bus.load_data = w; bus.load_last = 1'b1;
    bus.fetch_en = 1'b1; bus.pc = 32'h0;
    @(posedge clock); #1;
    idle();
    img.push_back(w);
    m_loading = 1'b0;
    total++;
    if (bus.instr_valid !== 1'b0 || bus.loading !== 1'b0)
      $display("FAIL simul_last_fetch: valid=%b loading=%b expected 0/0", bus.instr_valid, bus.loading);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      fetch_cycle(32'(i * 4), 1'b1);
      model_fetch(32'(i * 4), ei, em);
      total++;
      if (bus.instr !== ei || bus.instr_valid !== 1'b1 || bus.eof !== m_eof || bus.prog_size !== 9'd4)
        $display("FAIL fetch_word%0d: instr=%h valid=%b eof=%b size=%0d expected %h 1 %b 4",
                 i, bus.instr, bus.instr_valid, bus.eof, bus.prog_size, ei, m_eof);
      else passed++;
    end
    fetch_cycle(32'h0, 1'b0);
    total++;
    if (bus.instr !== 32'h0 || bus.instr_valid !== 1'b0 || bus.eof !== 1'b1)
      $display("FAIL done_idle: instr=%h valid=%b eof=%b expected 0 0 1", bus.instr, bus.instr_valid, bus.eof);
    else passed++;
    fetch_cycle(32'h0, 1'b1);
    model_fetch(32'h0, ei, em);
    total++;
    if (bus.instr !== ei || bus.instr_valid !== 1'b1 || bus.eof !== 1'b1)
      $display("FAIL done_refetch: instr=%h valid=%b eof=%b expected %h 1 1", bus.instr, bus.instr_valid, bus.eof, ei);
    else passed++;
  endtask

  task automatic test_full_load();
    logic [31:0] ei;
    logic        em;
    do_reset();
    load_words(DEPTH, 1'b0);
    total++;
    if (bus.load_ready !== 1'b0 || bus.loading !== 1'b0 || bus.prog_size !== 9'(DEPTH))
      $display("FAIL full_load: ready=%b loading=%b size=%0d expected 0 0 %0d",
               bus.load_ready, bus.loading, bus.prog_size, DEPTH);
    else passed++;
    load_words(2, 1'b1);
    total++;
    if (bus.prog_size !== 9'(DEPTH) || bus.loading !== 1'b0)
      $display("FAIL extra_load: size=%0d loading=%b expected %0d 0", bus.prog_size, bus.loading, DEPTH);
    else passed++;
    foreach (img[k]) if (k == 0 || k == 1 || k == DEPTH - 1) begin
      fetch_cycle(32'(k * 4), 1'b1);
      model_fetch(32'(k * 4), ei, em);
      total++;
      if (bus.instr !== ei || bus.eof !== 1'b0)
        $display("FAIL full_word%0d: instr=%h eof=%b expected %h 0", k, bus.instr, bus.eof, ei);
      else passed++;
    end
    fetch_cycle(32'(DEPTH * 4), 1'b1);
    model_fetch(32'(DEPTH * 4), ei, em);
    total++;
    if (bus.instr !== 32'h0 || bus.eof !== 1'b1 || bus.instr_valid !== 1'b1)
      $display("FAIL full_past_end: instr=%h eof=%b valid=%b expected 0 1 1", bus.instr, bus.eof, bus.instr_valid);
    else passed++;
  endtask

  task automatic test_reset_midload();
    logic [31:0] ei;
    logic        em;
    do_reset();
    load_words(2, 1'b0);
    do_reset();
    total++;
    if (bus.prog_size !== 9'd0 || bus.loading !== 1'b1)
      $display("FAIL midload_reset: size=%0d loading=%b expected 0 1", bus.prog_size, bus.loading);
    else passed++;
    load_words(3, 1'b1);
    fetch_cycle(32'd8, 1'b1);
    model_fetch(32'd8, ei, em);
    total++;
    if (bus.prog_size !== 9'd3 || bus.instr !== ei || bus.eof !== 1'b0)
      $display("FAIL reload_word2: size=%0d instr=%h eof=%b expected 3 %h 0", bus.prog_size, bus.instr, bus.eof, ei);
    else passed++;
  endtask

  task automatic test_wide_pc();
    logic [31:0] ei;
    logic        em;
    do_reset();
    load_words(4, 1'b1);
    fetch_cycle(32'hFFFF_FFF0, 1'b1);
    model_fetch(32'hFFFF_FFF0, ei, em);
    total++;
    if (bus.eof !== 1'b1 || bus.instr !== 32'h0 || m_eof !== 1'b1)
      $display("FAIL wide_pc: eof=%b instr=%h expected 1 00000000", bus.eof, bus.instr);
    else passed++;
  endtask

  task automatic test_misalign();
    logic [31:0] ei;
    logic        em;
    do_reset();
    load_words(4, 1'b1);
    fetch_cycle(32'd6, 1'b1);
    model_fetch(32'd6, ei, em);
    total++;
    if (bus.instr !== ei || bus.misalign !== em || bus.eof !== 1'b0 || bus.instr_valid !== 1'b1)
      $display("FAIL misalign_pc6: instr=%h mis=%b eof=%b valid=%b expected %h %b 0 1",
               bus.instr, bus.misalign, bus.eof, bus.instr_valid, ei, em);
    else passed++;
    fetch_cycle(32'd4, 1'b1);
    model_fetch(32'd4, ei, em);
    total++;
    if (bus.instr !== ei || bus.misalign !== 1'b0 || bus.eof !== 1'b0)
      $display("FAIL after_misalign: instr=%h mis=%b eof=%b expected %h 0 0", bus.instr, bus.misalign, bus.eof, ei);
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] ei, exp_instr, pc;
    logic        em, exp_mis;
    bit          en;
    int          n;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      n = $urandom_range(1, 24);
      load_words(n, 1'b1);
      exp_instr = 32'h0;
      for (int c = 0; c < 60; c++) begin
        en = ($urandom % 4) != 0;
        pc = 32'($urandom_range(0, n + 1) * 4);
        if ($urandom % 8 == 0) pc[1:0] = 2'($urandom);
        if ($urandom % 40 == 0) pc = $urandom;
        fetch_cycle(pc, en);
        exp_mis = 1'b0;
        if (en) begin
          model_fetch(pc, ei, em);
          exp_instr = ei;
          exp_mis   = em;
        end
        total++;
        if (bus.instr !== exp_instr || bus.instr_valid !== en || bus.eof !== m_eof ||
            bus.misalign !== exp_mis)
          $display("FAIL rand_r%0d_c%0d pc=%h en=%b: instr=%h valid=%b eof=%b mis=%b expected %h %b %b %b",
                   r, c, pc, en, bus.instr, bus.instr_valid, bus.eof, bus.misalign,
                   exp_instr, en, m_eof, exp_mis);
        else passed++;
      end
    end
  endtask

  initial begin
    idle();
    reset     = 1'b0;
    m_loading = 1'b1;
    m_eof     = 1'b0;
    test_reset();
    test_load_fetch();
    test_full_load();
    test_reset_midload();
    test_wide_pc();
    test_misalign();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
